// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: one outstanding req/gnt/rvalid fetch feeding a small
// {pc, instruction} FIFO for decode; redirects flush the buffer and restart fetch.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_redirect_valid,
  input  logic [31:0]                   i_redirect_addr,
  output logic                          o_imem_req,
  output logic [31:0]                   o_imem_addr,
  input  logic                          i_imem_gnt,
  input  logic                          i_imem_rvalid,
  input  logic [31:0]                   i_imem_rdata,
  output logic                          o_ins_valid,
  input  logic                          i_ins_ready,
  output logic [31:0]                   o_ins_data,
  output logic [31:0]                   o_ins_pc,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  state_t        r_state;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_pend_pc;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_mem_pc   [FIFO_DEPTH];
  logic [31:0]   r_mem_data [FIFO_DEPTH];

  logic [31:0] w_redir_addr;
  logic        w_grant;
  logic        w_push;
  logic        w_pop;
  logic        w_nonempty;

  assign w_redir_addr = i_redirect_addr & ~32'h3;
  assign w_nonempty   = (r_count != '0);

  // Issuing only in IDLE with a free slot reserves space for the response.
  assign o_imem_req  = i_rst && (r_state == S_IDLE) &&
                       (i_redirect_valid || (r_count < DEPTH_C));
  assign o_imem_addr = i_redirect_valid ? w_redir_addr : r_fetch_pc;
  assign w_grant     = o_imem_req && i_imem_gnt;

  assign w_push = (r_state == S_WAIT) && i_imem_rvalid && !i_redirect_valid;
  assign w_pop  = w_nonempty && i_ins_ready && !i_redirect_valid;

  assign o_ins_valid  = w_nonempty;
  assign o_ins_data   = w_nonempty ? r_mem_data[r_rptr] : '0;
  assign o_ins_pc     = w_nonempty ? r_mem_pc[r_rptr]   : '0;
  assign o_fifo_count = r_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers, independent of block ordering.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_pend_pc  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_pend_pc  <= o_imem_addr;
            r_fetch_pc <= o_imem_addr + 32'd4;
            r_state    <= S_WAIT;
          end else if (i_redirect_valid) begin
            r_fetch_pc <= w_redir_addr;
          end
        end
        S_WAIT: begin
          if (i_redirect_valid) r_fetch_pc <= w_redir_addr;
          if (i_imem_rvalid)         r_state <= S_IDLE;
          else if (i_redirect_valid) r_state <= S_DROP;
        end
        S_DROP: begin
          if (i_redirect_valid) r_fetch_pc <= w_redir_addr;
          if (i_imem_rvalid)    r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_redirect_valid) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; entries are only visible through
  // r_count, and the outputs are forced to zero while the buffer is empty.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem_pc[r_wptr]   <= r_pend_pc;
      r_mem_data[r_wptr] <= i_imem_rdata;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Randomized bench for inst_fetch_unit: a queue-based model of the fetch stream
// and a bench-side memory with random response latency.
module tb_inst_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins_data;
  logic [31:0] ins_pc;
  logic [$clog2(DEPTH):0] fifo_count;

  inst_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_redirect_valid(redirect_valid), .i_redirect_addr(redirect_addr),
    .o_imem_req(imem_req), .o_imem_addr(imem_addr),
    .i_imem_gnt(imem_gnt), .i_imem_rvalid(imem_rvalid), .i_imem_rdata(imem_rdata),
    .o_ins_valid(ins_valid), .i_ins_ready(ins_ready),
    .o_ins_data(ins_data), .o_ins_pc(ins_pc), .o_fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Expected decode stream: {pc, instruction} entries in program order.
  logic [63:0] exp_q[$];
  logic [31:0] m_next_pc;
  logic [31:0] m_pend_pc;
  bit          m_busy;
  bit          m_stale;

  // Bench memory: one accepted request, answered after a random delay.
  bit          mem_busy;
  int          mem_delay;
  logic [31:0] mem_data;

  int p_redir, p_ready, p_gnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 4))
      0:       return 32'h0040_0040;
      1:       return 32'h0040_0013;
      2:       return 32'hFFFF_FFFC;
      3:       return 32'hFFFF_FFF9;
      default: return $urandom;
    endcase
  endfunction

  task automatic check_outputs(input bit e_req, input logic [31:0] e_addr);
    logic [63:0] head;
    head = (exp_q.size() != 0) ? exp_q[0] : 64'd0;
    check("imem_req",   32'(imem_req),   32'(e_req));
    check("imem_addr",  imem_addr,       e_addr);
    check("ins_valid",  32'(ins_valid),  32'(exp_q.size() != 0));
    check("ins_pc",     ins_pc,          head[63:32]);
    check("ins_data",   ins_data,        head[31:0]);
    check("fifo_count", 32'(fifo_count), 32'(exp_q.size()));
  endtask

  task automatic step();
    logic [31:0] tgt;
    logic [31:0] e_addr;
    bit          e_req;
    bit          acc;
    bit          resp;
    @(negedge clk);
    redirect_valid = ($urandom_range(0, 99) < p_redir);
    redirect_addr  = pick_addr();
    ins_ready      = ($urandom_range(0, 99) < p_ready);
    // Hold off grants while a pre-reset response is still in flight.
    imem_gnt       = ($urandom_range(0, 99) < p_gnt) && !(mem_busy && !m_busy);
    resp           = mem_busy && (mem_delay == 0);
    imem_rvalid    = resp || (!mem_busy && ($urandom_range(0, 15) == 0));
    imem_rdata     = resp ? mem_data : $urandom;
    #1;
    tgt    = redirect_addr & ~32'h3;
    e_req  = !m_busy && (redirect_valid || exp_q.size() < DEPTH);
    e_addr = redirect_valid ? tgt : m_next_pc;
    check_outputs(e_req, e_addr);

    acc = e_req && imem_gnt;
    if (redirect_valid) exp_q.delete();
    else if (exp_q.size() != 0 && ins_ready) void'(exp_q.pop_front());
    if (mem_busy) begin
      if (resp) mem_busy = 0;
      else      mem_delay--;
    end
    if (m_busy && resp) begin
      if (!m_stale && !redirect_valid) exp_q.push_back({m_pend_pc, imem_rdata});
      m_busy  = 0;
      m_stale = 0;
    end else if (m_busy && redirect_valid) begin
      m_stale = 1;
    end
    if (acc) begin
      m_pend_pc = e_addr;
      m_next_pc = e_addr + 32'd4;
      m_busy    = 1;
      m_stale   = 0;
      mem_busy  = 1;
      mem_delay = $urandom_range(0, 3);
      mem_data  = $urandom;
    end else if (redirect_valid) begin
      m_next_pc = tgt;
    end
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    rst            = 1'b0;
    redirect_valid = 1'b0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    ins_ready      = 1'b0;
    #1;
    exp_q.delete();
    m_next_pc = RESET_PC;
    m_busy    = 0;
    m_stale   = 0;
    check_outputs(1'b0, RESET_PC);
    repeat (hold) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run(input int n, input int redir, input int ready, input int gnt);
    p_redir = redir;
    p_ready = ready;
    p_gnt   = gnt;
    repeat (n) step();
  endtask

  initial begin
    rst            = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    ins_ready      = 1'b0;
    mem_busy       = 0;
    mem_delay      = 0;
    mem_data       = '0;

    do_reset(2);
    run(40, 0, 100, 100);   // straight-line fetch from RESET_PC
    run(40, 0, 0, 100);     // decode stalled: buffer fills, requests stop
    run(20, 0, 100, 100);   // drain in order, fetch resumes
    run(1500, 15, 70, 70);  // mixed redirects, stalls and grant gaps

    // Reset while a fetch is outstanding; its response lands after release.
    p_redir = 0; p_ready = 100; p_gnt = 100;
    for (int i = 0; i < 100 && !m_busy; i++) step();
    if (!m_busy) begin
      n_checks++;
      n_errors++;
      $error("FAIL reach_wait: observed=idle expected=outstanding fetch");
    end
    do_reset(3);
    run(200, 10, 80, 80);
    run(500, 30, 60, 60);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
